zoled_wave_plotter: RTL and testbench
=====================================

// Module: zoled_wave_plotter
// PURPOSE
// - Streaming waveform plotter between a sample source (SDRAM read-back / ROM) and the ZOLED_Module2 command port.
// - Accepts 6-bit amplitude samples on a valid/ready handshake and maps each one to an OLED page and bit mask.
// - Draws one sample per column, left to right, wrapping at X_MAX; optionally blanks each column before drawing it.
// - Owns OLED bring-up (INIT_REGS, CLS_GRAM) so the top level only supplies start and samples.
// PARAMETERS
// - X_MAX        7'd127     last column index; x wraps X_MAX->0
// - ERASE_EN     1'b1       1: write 0x00 to pages 0..7 of a column before drawing it
// - DONE_TIMEOUT 20'd500000 clk cycles to wait for oled_done before flagging err
// PORTS
// - clk_10MHz  in   1  system clock, 10 MHz
// - rst_n      in   1  asynchronous, active-low reset
// - start      in   1  1-cycle pulse; honoured only in ST_IDLE
// - s_valid    in   1  sample valid
// - s_data     in   6  sample amplitude y, 0=bottom row, 63=top row
// - s_ready    out  1  high only in ST_WAIT; a sample transfers when s_valid&&s_ready
// - oled_en    out  1  to ZOLED_Module2.en
// - oled_cmd   out  4  CMD_INIT_REGS / CMD_CLS_GRAM / CMD_WR_GRAM
// - oled_data  out  8  GRAM byte
// - oled_x     out  8  column 0..127
// - oled_y     out  3  page 0..7
// - oled_done  in   1  from ZOLED_Module2.done
// - busy       out  1  high in every state except ST_IDLE
// - col_x      out  7  column the next accepted sample will be drawn in
// - frame_done out  1  1-cycle pulse when column X_MAX completes
// - err        out  1  sticky; set on timeout, cleared by reset or start
// BEHAVIOUR
// - Reset values: all outputs 0, oled_cmd=CMD_INIT_REGS, state=ST_IDLE, col_x=0. Reset aborts any command immediately; no resume.
// - Command handshake:
//   - Drive cmd/data/x/y and raise oled_en in the same cycle; hold all of them stable while oled_en=1.
//   - On the first cycle oled_done=1, drop oled_en and advance. oled_en stays low for at least 1 cycle between commands.
// - Timeout: a 20-bit counter runs while oled_en=1. On reaching DONE_TIMEOUT: err<=1, oled_en<=0, go to ST_IDLE.
// - Y mapping (combinational): r=63-y; page=r[5:3]; mask=8'h01<<r[2:0].
//   - y=63 -> page0 mask 0x01; y=0 -> page7 mask 0x80.
// - States:
//   - ST_IDLE: on start, clear err and col_x -> ST_INIT.
//   - ST_INIT: CMD_INIT_REGS, then -> ST_CLS.
//   - ST_CLS: CMD_CLS_GRAM, then -> ST_WAIT.
//   - ST_WAIT: s_ready=1. On transfer, latch page/mask in the same edge, s_ready drops next cycle -> ST_ERASE if ERASE_EN, else ST_DRAW.
//   - ST_ERASE: 8 CMD_WR_GRAM, data=0x00, x=col_x, y=0..7 in order (3-bit page counter) -> ST_DRAW.
//   - ST_DRAW: CMD_WR_GRAM, data=mask, x=col_x, y=page -> ST_NEXT.
//   - ST_NEXT: 1 cycle. If col_x==X_MAX: col_x<=0 and pulse frame_done; else col_x<=col_x+1. Then -> ST_WAIT.
// - start outside ST_IDLE is ignored. start and s_valid together in ST_IDLE: start wins and the sample is not accepted.
// - An upstream stall (s_valid=0 in ST_WAIT) waits indefinitely with oled_en=0.
// - Per sample, OLED commands = ERASE_EN ? 9 : 1.
// STRUCTURE
// - Command codes come from the shared ZOLED_CmdList.v defines. Add the state encodings (4-bit localparams) to a shared zoled_plot_defs.v.
// - One sub-module: zoled_y_to_page (combinational y -> page/mask), reusable by future drawPixel/drawLine blocks.
// - Main FSM, timeout counter, page counter and col_x counter stay in this file.
// TESTING
// - Bench model of ZOLED_Module2 answers done 5 cycles after en rises and logs each command.
// - T1 start after reset -> INIT_REGS then CLS_GRAM logged, s_ready=1 only afterwards, busy=1 from start+1.
// - T2 ERASE_EN=1, sample y=0 at col 0 -> 8 writes (x=0, y=0..7, data=00), then (x=0, y=7, data=80); col_x=1.
// - T3 sample y=63 then y=37 -> draws (x0,p0,01) then (x1,p3,04); en low >=1 cycle between all commands.
// - T4 128 samples y=i/2 -> frame_done exactly once after column 127; col_x=0; 129th sample draws at x=0.
// - T5 model never asserts done, DONE_TIMEOUT=100 -> err=1, oled_en=0, state ST_IDLE; next start clears err.
// - T6 assert rst_n mid-ST_ERASE -> all outputs at reset values in the same cycle; start re-runs INIT.

Source files
------------

// File: rtl/zoled_wave_plotter_pkg.sv
// Shared definitions for the ZOLED waveform plotter.
// Holds the ZOLED_Module2 command codes and the plotter FSM state encoding
// so the top level, its helpers and the bench all agree on them.
package zoled_wave_plotter_pkg;

  // ZOLED_Module2 command codes.
  // INIT_REGS is 0, so the reset value of oled_cmd is all zeros.
  localparam logic [3:0] CMD_INIT_REGS = 4'h0;
  localparam logic [3:0] CMD_CLS_GRAM  = 4'h1;
  localparam logic [3:0] CMD_WR_GRAM   = 4'h2;

  localparam logic [2:0] PAGE_LAST = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_CLS   = 4'd2,
    ST_WAIT  = 4'd3,
    ST_ERASE = 4'd4,
    ST_DRAW  = 4'd5,
    ST_NEXT  = 4'd6
  } plot_state_e;

endpackage

// File: rtl/zoled_wave_plotter_y_to_page.sv
// zoled_y_to_page: combinational mapping of a 6-bit amplitude to an OLED
// page and the bit mask within that page. y=63 is the top row (page 0, bit 0)
// and y=0 is the bottom row (page 7, bit 7).
// Ports:
//   y_i    [5:0]  amplitude, 0 = bottom row
//   page_o [2:0]  GRAM page 0..7
//   mask_o [7:0]  one-hot row mask within the page
module zoled_y_to_page (
  input  logic [5:0] y_i,
  output logic [2:0] page_o,
  output logic [7:0] mask_o
);

  logic [5:0] row;

  // Screen rows count down from the top, amplitude counts up from the bottom.
  assign row    = 6'd63 - y_i;
  assign page_o = row[5:3];
  assign mask_o = 8'h01 << row[2:0];

endmodule

// File: rtl/zoled_wave_plotter.sv
// zoled_wave_plotter: streams 6-bit samples onto the OLED, one column per
// sample, left to right, wrapping at X_MAX. Brings the panel up (INIT_REGS,
// CLS_GRAM) on start, then optionally blanks each column before drawing it.
// Ports:
//   clk_10MHz, rst_n (async, active-low)
//   start                 1-cycle pulse, honoured only when idle
//   s_valid/s_data/s_ready sample handshake, ready only while waiting
//   oled_en/cmd/data/x/y  command to ZOLED_Module2, oled_done its answer
//   busy, col_x, frame_done, err  status
module zoled_wave_plotter
  import zoled_wave_plotter_pkg::*;
#(
  parameter logic [6:0]  X_MAX        = 7'd127,
  parameter logic        ERASE_EN     = 1'b1,
  parameter logic [19:0] DONE_TIMEOUT = 20'd500000
) (
  input  logic       clk_10MHz,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_valid,
  input  logic [5:0] s_data,
  output logic       s_ready,
  output logic       oled_en,
  output logic [3:0] oled_cmd,
  output logic [7:0] oled_data,
  output logic [7:0] oled_x,
  output logic [2:0] oled_y,
  input  logic       oled_done,
  output logic       busy,
  output logic [6:0] col_x,
  output logic       frame_done,
  output logic       err
);

  localparam logic [19:0] TMO_LAST = DONE_TIMEOUT - 20'd1;

  plot_state_e state_q, state_d;
  logic        en_q, en_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  x_q, x_d;
  logic [2:0]  y_q, y_d;
  logic [19:0] tmo_q, tmo_d;
  logic [2:0]  pg_q, pg_d;
  logic [6:0]  col_q, col_d;
  logic [2:0]  page_q, page_d;
  logic [7:0]  mask_q, mask_d;
  logic        err_q, err_d;
  logic        fd_q, fd_d;

  logic [2:0]  samp_page;
  logic [7:0]  samp_mask;

  zoled_y_to_page u_y_to_page (
    .y_i    (s_data),
    .page_o (samp_page),
    .mask_o (samp_mask)
  );

  always_ff @(posedge clk_10MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      cmd_q   <= CMD_INIT_REGS;
      data_q  <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 3'd0;
      tmo_q   <= 20'd0;
      pg_q    <= 3'd0;
      col_q   <= 7'd0;
      page_q  <= 3'd0;
      mask_q  <= 8'h00;
      err_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tmo_q   <= tmo_d;
      pg_q    <= pg_d;
      col_q   <= col_d;
      page_q  <= page_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      fd_q    <= fd_d;
    end
  end

  // Command states share one pattern: with en low, load the command and
  // raise en; with en high, wait for done, then drop en and advance. The
  // drop-then-raise sequence guarantees a low cycle between commands.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    x_d     = x_q;
    y_d     = y_q;
    tmo_d   = tmo_q;
    pg_d    = pg_q;
    col_d   = col_q;
    page_d  = page_q;
    mask_d  = mask_q;
    err_d   = err_q;
    fd_d    = 1'b0;

    if (en_q) begin
      if (oled_done) begin
        en_d  = 1'b0;
        tmo_d = 20'd0;
      end else if (tmo_q == TMO_LAST) begin
        // Panel stopped answering: abandon the command and park idle.
        en_d    = 1'b0;
        tmo_d   = 20'd0;
        err_d   = 1'b1;
        pg_d    = 3'd0;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 20'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          col_d   = 7'd0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (!en_q) begin
          en_d   = 1'b1;
          cmd_d  = CMD_INIT_REGS;
          data_d = 8'h00;
          x_d    = 8'h00;
          y_d    = 3'd0;
        end else if (oled_done) begin
          state_d = ST_CLS;
        end
      end
      ST_CLS: begin
        if (!en_q) begin
          en_d   = 1'b1;
          cmd_d  = CMD_CLS_GRAM;
          data_d = 8'h00;
          x_d    = 8'h00;
          y_d    = 3'd0;
        end else if (oled_done) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_valid) begin
          page_d  = samp_page;
          mask_d  = samp_mask;
          pg_d    = 3'd0;
          state_d = ERASE_EN ? ST_ERASE : ST_DRAW;
        end
      end
      ST_ERASE: begin
        if (!en_q) begin
          en_d   = 1'b1;
          cmd_d  = CMD_WR_GRAM;
          data_d = 8'h00;
          x_d    = {1'b0, col_q};
          y_d    = pg_q;
        end else if (oled_done) begin
          if (pg_q == PAGE_LAST) begin
            pg_d    = 3'd0;
            state_d = ST_DRAW;
          end else begin
            pg_d = pg_q + 3'd1;
          end
        end
      end
      ST_DRAW: begin
        if (!en_q) begin
          en_d   = 1'b1;
          cmd_d  = CMD_WR_GRAM;
          data_d = mask_q;
          x_d    = {1'b0, col_q};
          y_d    = page_q;
        end else if (oled_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (col_q == X_MAX) begin
          col_d = 7'd0;
          fd_d  = 1'b1;
        end else begin
          col_d = col_q + 7'd1;
        end
        state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready    = (state_q == ST_WAIT);
  assign busy       = (state_q != ST_IDLE);
  assign oled_en    = en_q;
  assign oled_cmd   = cmd_q;
  assign oled_data  = data_q;
  assign oled_x     = x_q;
  assign oled_y     = y_q;
  assign col_x      = col_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_zoled_wave_plotter.sv
module tb_zoled_wave_plotter;
  import zoled_wave_plotter_pkg::*;

  typedef logic [22:0] cmd_t;  // {cmd, data, x, y}

  logic       clk_10MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic       s_valid   = 1'b0;
  logic [5:0] s_data    = 6'd0;
  logic       s_ready;
  logic       oled_en;
  logic [3:0] oled_cmd;
  logic [7:0] oled_data;
  logic [7:0] oled_x;
  logic [2:0] oled_y;
  logic       oled_done = 1'b0;
  logic       busy;
  logic [6:0] col_x;
  logic       frame_done;
  logic       err;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mute     = 1'b0;
  int   exp_col  = 0;

  cmd_t exp_q[$];
  cmd_t obs_q[$];

  // monitor state
  logic en_prev = 1'b0;
  cmd_t held    = '0;
  bit   stab_viol = 1'b0;
  int   fd_cnt  = 0;
  int   mcnt    = 0;

  zoled_wave_plotter #(
    .X_MAX        (7'd127),
    .ERASE_EN     (1'b1),
    .DONE_TIMEOUT (20'd100)
  ) dut (
    .clk_10MHz  (clk_10MHz),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .oled_en    (oled_en),
    .oled_cmd   (oled_cmd),
    .oled_data  (oled_data),
    .oled_x     (oled_x),
    .oled_y     (oled_y),
    .oled_done  (oled_done),
    .busy       (busy),
    .col_x      (col_x),
    .frame_done (frame_done),
    .err        (err)
  );

  always #50 clk_10MHz = ~clk_10MHz;

  // ZOLED_Module2 model: done one cycle, 5 cycles after en rises.
  always @(posedge clk_10MHz) begin
    if (oled_en) begin
      mcnt      <= mcnt + 1;
      oled_done <= (mcnt == 4) && !mute;
    end else begin
      mcnt      <= 0;
      oled_done <= 1'b0;
    end
  end

  // Command logger and hold-stable watcher.
  always @(posedge clk_10MHz) begin
    en_prev <= oled_en;
    if (oled_en && !en_prev) begin
      obs_q.push_back({oled_cmd, oled_data, oled_x, oled_y});
      held <= {oled_cmd, oled_data, oled_x, oled_y};
    end else if (oled_en && en_prev && rst_n &&
                 ({oled_cmd, oled_data, oled_x, oled_y} !== held)) begin
      stab_viol <= 1'b1;
    end
  end

  always @(negedge clk_10MHz) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_10MHz);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_10MHz);
    start = 1'b0;
    exp_col = 0;
    exp_q.push_back({CMD_INIT_REGS, 8'h00, 8'h00, 3'd0});
    exp_q.push_back({CMD_CLS_GRAM,  8'h00, 8'h00, 3'd0});
  endtask

  // Drive one sample and push the expected erase+draw commands.
  task automatic send_sample(input logic [5:0] y, output bit ok);
    int r;
    wait_ready(2000, ok);
    if (!ok) return;
    s_valid = 1'b1;
    s_data  = y;
    r = 63 - int'(y);
    for (int p = 0; p < 8; p++)
      exp_q.push_back({CMD_WR_GRAM, 8'h00, 8'(exp_col), 3'(p)});
    exp_q.push_back({CMD_WR_GRAM, 8'(1 << (r % 8)), 8'(exp_col), 3'(r / 8)});
    exp_col = (exp_col == 127) ? 0 : exp_col + 1;
    @(negedge clk_10MHz);
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_10MHz);
    n_checks++;
    if ({oled_en, oled_cmd, oled_data, oled_x, oled_y} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_oled: got en=%b cmd=%h data=%h x=%h y=%h, expected all 0",
               oled_en, oled_cmd, oled_data, oled_x, oled_y);
    end
    n_checks++;
    if ({s_ready, busy, col_x, frame_done, err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_status: got ready=%b busy=%b col=%0d fd=%b err=%b, expected all 0",
               s_ready, busy, col_x, frame_done, err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_10MHz);
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got busy=%b ready=%b, expected 0 0", busy, s_ready);
    end
  endtask

  task automatic test_init();
    bit ok;
    cmd_t e, o;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_busy: got busy=%b ready=%b, expected 1 0", busy, s_ready);
    end
    wait_ready(200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL t1_ready_timeout: got s_ready=0, expected 1 within 200 cycles");
    end
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL t1_cmd_count: got %0d commands before ready, expected 2", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t1_log: got no command, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL t1_log: got %h, expected %h", o, e); end
      end
    end
  endtask

  task automatic test_erase_draw();
    bit ok;
    cmd_t e, o;
    send_sample(6'd0, ok);
    wait_ready(300, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL t2_ready_timeout: got s_ready=0, expected 1 within 300 cycles");
    end
    n_checks++;
    if (obs_q.size() != 9) begin
      n_fail++;
      $display("FAIL t2_cmd_count: got %0d, expected 9", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t2_log: got no command, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL t2_log: got %h, expected %h", o, e); end
      end
    end
    n_checks++;
    if (col_x !== 7'd1) begin
      n_fail++;
      $display("FAIL t2_col_x: got %0d, expected 1", col_x);
    end
  endtask

  task automatic test_two_samples();
    bit ok;
    cmd_t e, o;
    send_sample(6'd63, ok);
    send_sample(6'd37, ok);
    wait_ready(300, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL t3_ready_timeout: got s_ready=0, expected 1 within 300 cycles");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t3_log: got no command, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL t3_log: got %h, expected %h", o, e); end
      end
    end
    n_checks++;
    if (stab_viol !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_hold_stable: got command change while en=1, expected none");
    end
    n_checks++;
    if (col_x !== 7'd3) begin
      n_fail++;
      $display("FAIL t3_col_x: got %0d, expected 3", col_x);
    end
  endtask

  task automatic test_frame_wrap();
    bit ok;
    int base;
    cmd_t e, o;
    rst_n = 1'b0;
    @(negedge clk_10MHz);
    rst_n = 1'b1;
    @(negedge clk_10MHz);
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    base = fd_cnt;
    for (int i = 0; i < 127; i++) send_sample(6'(i / 2), ok);
    wait_ready(300, ok);
    @(negedge clk_10MHz);
    n_checks++;
    if (fd_cnt - base != 0) begin
      n_fail++;
      $display("FAIL t4_early_frame_done: got %0d pulses after 127 columns, expected 0", fd_cnt - base);
    end
    send_sample(6'd63, ok);
    wait_ready(300, ok);
    repeat (2) @(negedge clk_10MHz);
    n_checks++;
    if (fd_cnt - base != 1) begin
      n_fail++;
      $display("FAIL t4_frame_done: got %0d pulses, expected 1", fd_cnt - base);
    end
    n_checks++;
    if (col_x !== 7'd0) begin
      n_fail++;
      $display("FAIL t4_col_wrap: got %0d, expected 0", col_x);
    end
    send_sample(6'd20, ok);
    wait_ready(300, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL t4_ready_timeout: got s_ready=0, expected 1 within 300 cycles");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t4_log: got no command, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL t4_log: got %h, expected %h", o, e); end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit idle;
    send_sample(6'd5, ok);
    mute = 1'b1;
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_10MHz);
      if (!busy) begin idle = 1'b1; break; end
    end
    n_checks++;
    if (!idle) begin
      n_fail++;
      $display("FAIL t5_idle_timeout: got busy=1, expected 0 within 400 cycles");
    end
    n_checks++;
    if (err !== 1'b1 || oled_en !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_err: got err=%b en=%b ready=%b, expected 1 0 0", err, oled_en, s_ready);
    end
    repeat (3) @(negedge clk_10MHz);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_err_sticky: got %b, expected 1", err);
    end
    mute = 1'b0;
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_restart: got err=%b busy=%b, expected 0 1", err, busy);
    end
    wait_ready(200, ok);
    n_checks++;
    if (!ok || obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL t5_reinit: got ready=%b cmds=%0d, expected 1 2", ok, obs_q.size());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_erase();
    bit ok;
    bit hit;
    cmd_t e, o;
    send_sample(6'd40, ok);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_10MHz);
      if (obs_q.size() >= 3 && oled_en) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL t6_reach_erase: got %0d commands, expected 3 within 200 cycles", obs_q.size());
    end
    #10 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({oled_en, oled_cmd, oled_data, oled_x, oled_y} !== 24'd0 ||
        {s_ready, busy, col_x, frame_done, err} !== 11'd0) begin
      n_fail++;
      $display("FAIL t6_async_reset: got en=%b cmd=%h data=%h x=%h y=%h busy=%b col=%0d, expected all 0",
               oled_en, oled_cmd, oled_data, oled_x, oled_y, busy, col_x);
    end
    @(negedge clk_10MHz);
    rst_n = 1'b1;
    @(negedge clk_10MHz);
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    send_sample(6'd31, ok);
    wait_ready(300, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL t6_ready_timeout: got s_ready=0, expected 1 within 300 cycles");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t6_log: got no command, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL t6_log: got %h, expected %h", o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_erase_draw();
    test_two_samples();
    test_frame_wrap();
    test_timeout();
    test_reset_mid_erase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
